arb_push_stage: RTL and testbench
=================================

# arb_push_stage

Round-robin arbitration stage that sits directly upstream of the first fifo in the composed scoreboard chain. It selects one of `NREQ` requesters per cycle, captures the winner's word into a one-entry output register, and drives the downstream fifo's `push`/`data_in` while honouring its `full` flag. Fairness is rotating priority, so a held request is never starved.

## Interface
- `WIDTH`, default `FIFO_DWIDTH` (8): data word width.
- `QWID`, default `ARB_QWID` (2): requester index width.
- `NREQ`, default `2**QWID` (4): number of requesters; must equal `2**QWID`.

- `clk`  in  1  single clock; all state on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  per-requester valid.
- `data_in`  in  NREQ*WIDTH  requester i word at bits `[i*WIDTH +: WIDTH]`.
- `grant`  out  NREQ  one-hot accept; requester i's word is consumed in the cycle `req[i] && grant[i]`.
- `full`  in  1  downstream fifo full.
- `push`  out  1  downstream push strobe.
- `data_out`  out  WIDTH  word presented with `push`.
- `grant_idx`  out  QWID  index of the word currently held in the output register.
- `out_vld`  out  1  output register occupied.

## Operation
- State: `ptr` (QWID bits, highest-priority index), `out_vld`, `data_q` (WIDTH), `idx_q` (QWID).
- `push = out_vld && !full`. The downstream is never pushed while full.
- `load = !out_vld || push`. The stage accepts a new word when empty or draining this cycle.
- Selection: first i with `req[i]` searching `ptr, ptr+1, …, NREQ-1, 0, …` (mod NREQ). `grant` is that one-hot only when `load`. Otherwise `grant = 0`.
- On a grant to i: `data_q <= data_in[i]`, `idx_q <= i`, `out_vld <= 1`, `ptr <= i+1` (wraps from NREQ-1 to 0).
- On `push` with no grant: `out_vld <= 0`. `ptr`, `data_q` and `idx_q` hold.
- No request with `load` asserted: `ptr` holds.
- Requester protocol: once raised, `req[i]` and its data stay stable until granted. Dropping `req` early is legal; the word is then lost and no grant is issued for it.
- Fairness: a requester holding `req` is granted within NREQ grants.
- `grant` is combinational from `req`, `ptr`, `out_vld` and `full`, and has no combinational dependence on `data_in`.

## Timing
- Reset (async assert, sync release) sets `ptr=0`, `out_vld=0`, `data_q=0`, `idx_q=0`. Resulting outputs: `push=0`, `grant=0`, `data_out=0`, `grant_idx=0`.
- Latency: grant at cycle t puts the word on `data_out` at t+1. `push` asserts at t+1 if `!full`.
- Throughput: 1 word/cycle while `full=0`. A push and a new grant occur in the same cycle.
- Full persistently high with `out_vld=1`: `data_out` holds, `grant=0`, `ptr` frozen.
- `full` falls: `push=1` in that cycle, with a simultaneous grant if any `req` is set.
- Reset mid-operation: the held word is discarded and not pushed. `grant` drops immediately.
- A single requester alone is granted every cycle (ptr wraps past it each time).

## Structure
- Package `arb_pkg`: `ARB_QWID`, `ARB_NREQ = 2**ARB_QWID`, index typedef `arb_idx_t`, one-hot typedef `arb_vec_t`.
- Sub-module `rr_pick` (combinational): inputs `req`, `ptr`; outputs one-hot `sel`, `sel_idx`, `any`. It is implemented as a rotate, then a fixed-priority find-first, then a rotate back.
- Top level holds the registers and the load/push logic.
- Formal harness: instantiate the existing fifo and scoreboard downstream. Assert:
  - `!(push && full)`;
  - `$onehot0(grant)`;
  - `grant` is a subset of `req`.

## Test plan
- Reset, then `req=4'b1111` with `full=0` → grants go 0,1,2,3,0 on consecutive cycles; `push` is high from cycle 2; `grant_idx` follows 0,1,2,3 one cycle later.
- `req=4'b0100` only, data 0xA5 → `grant=4'b0100` every cycle; `data_out=0xA5` with `push=1` each cycle after the first.
- Word 0x3C in the register, `full=1` for 5 cycles → `push=0`, `grant=0`, `data_out=0x3C` stable. `full` falls → `push=1` and a new grant in the same cycle.
- `ptr=3` with `req=4'b1001` → grant 3, then 0 (wrap), then 3.
- Assert `rst` while `out_vld=1` and requests are pending → all outputs 0 immediately. After release, arbitration restarts at index 0.
- Random `req`/`full` for 10k cycles → every held request is granted within 4 grants, and the pushed sequence matches the grant order.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared sizes and index/vector types for the round-robin push stage.
package arb_pkg;

    localparam int unsigned FIFO_DWIDTH = 8;
    localparam int unsigned ARB_QWID    = 2;
    localparam int unsigned ARB_NREQ    = 1 << ARB_QWID;

    typedef logic [ARB_QWID-1:0] arb_idx_t;
    typedef logic [ARB_NREQ-1:0] arb_vec_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: rotate by ptr, find first, rotate back.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned QWID = ARB_QWID,
    parameter int unsigned NREQ = 1 << QWID
) (
    input  logic [NREQ-1:0] req,
    input  logic [QWID-1:0] ptr,
    output logic [NREQ-1:0] sel,
    output logic [QWID-1:0] sel_idx,
    output logic            any
);

    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_rot_sel;
    logic [QWID-1:0] w_first;

    // Rotate so that position 0 corresponds to the current highest-priority requester.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = req[QWID'(QWID'(i) + ptr)];
        end
    end

    // Fixed-priority find-first on the rotated vector (lowest index wins).
    always_comb begin
        w_first = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_first = QWID'(i);
            end
        end
    end

    assign any = |w_rot;

    always_comb begin
        w_rot_sel = '0;
        if (any) begin
            w_rot_sel[w_first] = 1'b1;
        end
    end

    // Rotate the one-hot back into requester numbering.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel[QWID'(QWID'(i) + ptr)] = w_rot_sel[i];
        end
    end

    assign sel_idx = QWID'(w_first + ptr);

endmodule

// File: rtl/arb_push_stage.sv
// Round-robin arbiter feeding a one-entry output register that pushes into a downstream fifo.
module arb_push_stage
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_DWIDTH,
    parameter int unsigned QWID  = ARB_QWID,
    parameter int unsigned NREQ  = 1 << QWID
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       grant,
    input  logic                  full,
    output logic                  push,
    output logic [WIDTH-1:0]      data_out,
    output logic [QWID-1:0]       grant_idx,
    output logic                  out_vld
);

    logic [QWID-1:0]  r_ptr;
    logic [QWID-1:0]  r_idx;
    logic [WIDTH-1:0] r_data;
    logic             r_out_vld;

    logic [NREQ-1:0]  w_sel;
    logic [QWID-1:0]  w_sel_idx;
    logic             w_any;
    logic             w_push;
    logic             w_load;
    logic             w_take;
    logic [WIDTH-1:0] w_word;

    rr_pick #(
        .QWID (QWID),
        .NREQ (NREQ)
    ) u_pick (
        .req     (req),
        .ptr     (r_ptr),
        .sel     (w_sel),
        .sel_idx (w_sel_idx),
        .any     (w_any)
    );

    assign w_push = r_out_vld && !full;
    assign w_load = !r_out_vld || w_push;
    // Reset gating keeps grant low for the whole time rst is held, not just after the edge.
    assign w_take = w_load && w_any && !rst;

    // Winner's word; selected by index so grant never depends on data_in.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel_idx == QWID'(i)) begin
                w_word = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_out_vld <= 1'b0;
        end else if (w_take) begin
            r_ptr     <= QWID'(w_sel_idx + QWID'(1));
            r_idx     <= w_sel_idx;
            r_data    <= w_word;
            r_out_vld <= 1'b1;
        end else if (w_push) begin
            r_out_vld <= 1'b0;
        end
    end

    assign grant     = w_take ? w_sel : '0;
    assign push      = w_push;
    assign data_out  = r_data;
    assign grant_idx = r_idx;
    assign out_vld   = r_out_vld;

`ifdef FORMAL
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_grant_subset: assert property (@(posedge clk) disable iff (rst) (grant & ~req) == '0);
`endif

endmodule

// File: tb/tb_arb_push_stage.sv
// Scoreboard bench for arb_push_stage: reference arbiter model plus directed and random scenarios.
module tb_arb_push_stage;

    localparam int W = 8;
    localparam int Q = 2;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data_in = '0;
    logic [N-1:0]   grant;
    logic           full = 1'b0;
    logic           push;
    logic [W-1:0]   data_out;
    logic [Q-1:0]   grant_idx;
    logic           out_vld;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic [Q-1:0] i;
    } sb_t;

    sb_t          sb[$];
    logic [Q-1:0] m_ptr;
    logic         m_vld;
    int           wait_cnt[N];

    always #5 clk = ~clk;

    arb_push_stage dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .full      (full),
        .push      (push),
        .data_out  (data_out),
        .grant_idx (grant_idx),
        .out_vld   (out_vld)
    );

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] r, input logic [Q-1:0] p,
                                                 input logic vld, input logic f);
        logic [N-1:0] g;
        g = '0;
        if (!(vld && f)) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (int'(p) + k) % N;
                if (r[j] && g == '0) g[j] = 1'b1;
            end
        end
        return g;
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic         ep;
        sb_t          e;
        if (rst) begin
            m_ptr = '0;
            m_vld = 1'b0;
            sb.delete();
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else begin
            ep = m_vld && !full;
            eg = model_grant(req, m_ptr, m_vld, full);
            checks++;
            if (grant !== eg) begin
                errors++;
                $display("FAIL sb_grant t=%0t got %b want %b", $time, grant, eg);
            end
            checks++;
            if (push !== ep) begin
                errors++;
                $display("FAIL sb_push t=%0t got %b want %b", $time, push, ep);
            end
            checks++;
            if (out_vld !== m_vld) begin
                errors++;
                $display("FAIL sb_out_vld t=%0t got %b want %b", $time, out_vld, m_vld);
            end
            if (push === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty t=%0t push with no expected word", $time);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (data_out !== e.d) begin
                        errors++;
                        $display("FAIL sb_data t=%0t got %h want %h", $time, data_out, e.d);
                    end
                    checks++;
                    if (grant_idx !== e.i) begin
                        errors++;
                        $display("FAIL sb_idx t=%0t got %0d want %0d", $time, grant_idx, e.i);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (grant[i] === 1'b1) begin
                    checks++;
                    if (wait_cnt[i] > N - 1) begin
                        errors++;
                        $display("FAIL fairness req%0d waited %0d grants want <= %0d", i, wait_cnt[i], N - 1);
                    end
                    wait_cnt[i] = 0;
                end else if (req[i] && grant != '0) begin
                    wait_cnt[i]++;
                end else if (!req[i]) begin
                    wait_cnt[i] = 0;
                end
            end
            for (int j = 0; j < N; j++) begin
                if (eg[j]) begin
                    sb.push_back('{d: data_in[j*W +: W], i: Q'(j)});
                    m_vld = 1'b1;
                    m_ptr = Q'(j + 1);
                end
            end
            if (eg == '0 && ep) m_vld = 1'b0;
        end
    end

    task automatic do_reset();
        req  = '0;
        full = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({push, grant, data_out, grant_idx, out_vld} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got push=%b grant=%b data=%h idx=%0d vld=%b want all 0",
                     push, grant, data_out, grant_idx, out_vld);
        end
        do_reset();
    endtask

    task automatic test_all_req();
        logic [N-1:0] exp_g;
        do_reset();
        req = 4'b1111;
        data_in = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_g = '0;
            exp_g[k % N] = 1'b1;
            checks++;
            if (grant !== exp_g) begin
                errors++;
                $display("FAIL all_req_grant k=%0d got %b want %b", k, grant, exp_g);
            end
            checks++;
            if (push !== (k >= 1)) begin
                errors++;
                $display("FAIL all_req_push k=%0d got %b want %b", k, push, k >= 1);
            end
            if (k >= 1) begin
                checks++;
                if (grant_idx !== Q'(k - 1)) begin
                    errors++;
                    $display("FAIL all_req_idx k=%0d got %0d want %0d", k, grant_idx, k - 1);
                end
            end
            @(posedge clk);
            #1;
        end
        req = '0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        data_in = {8'h00, 8'hA5, 8'h00, 8'h00};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (grant !== 4'b0100) begin
                errors++;
                $display("FAIL single_grant k=%0d got %b want 0100", k, grant);
            end
            if (k >= 1) begin
                checks++;
                if (push !== 1'b1 || data_out !== 8'hA5) begin
                    errors++;
                    $display("FAIL single_push k=%0d got push=%b data=%h want push=1 data=a5", k, push, data_out);
                end
            end
            @(posedge clk);
            #1;
        end
        req = '0;
    endtask

    task automatic test_full_hold();
        do_reset();
        full = 1'b1;
        req = 4'b0010;
        data_in = {8'h00, 8'h00, 8'h3C, 8'h00};
        @(negedge clk);
        @(posedge clk);
        #1;
        req = 4'b0100;
        data_in = {8'h00, 8'h77, 8'h3C, 8'h00};
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (push !== 1'b0 || grant !== '0 || data_out !== 8'h3C) begin
                errors++;
                $display("FAIL full_hold got push=%b grant=%b data=%h want push=0 grant=0000 data=3c",
                         push, grant, data_out);
            end
            @(posedge clk);
            #1;
        end
        full = 1'b0;
        @(negedge clk);
        checks++;
        if (push !== 1'b1 || grant !== 4'b0100) begin
            errors++;
            $display("FAIL full_release got push=%b grant=%b want push=1 grant=0100", push, grant);
        end
        @(posedge clk);
        #1;
        req = '0;
        @(negedge clk);
        checks++;
        if (push !== 1'b1 || data_out !== 8'h77) begin
            errors++;
            $display("FAIL full_next got push=%b data=%h want push=1 data=77", push, data_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        logic [N-1:0] exp_g[3];
        exp_g[0] = 4'b1000;
        exp_g[1] = 4'b0001;
        exp_g[2] = 4'b1000;
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        @(posedge clk);
        #1;
        req = 4'b1001;
        data_in = {8'hD3, 8'h00, 8'h00, 8'hD0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (grant !== exp_g[k]) begin
                errors++;
                $display("FAIL wrap_grant k=%0d got %b want %b", k, grant, exp_g[k]);
            end
            @(posedge clk);
            #1;
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1111;
        data_in = {8'h44, 8'h33, 8'h22, 8'h5A};
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({push, grant, data_out, grant_idx, out_vld} !== '0) begin
            errors++;
            $display("FAIL reset_mid got push=%b grant=%b data=%h idx=%0d vld=%b want all 0",
                     push, grant, data_out, grant_idx, out_vld);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001 || push !== 1'b0) begin
            errors++;
            $display("FAIL reset_restart got grant=%b push=%b want grant=0001 push=0", grant, push);
        end
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] g;
        do_reset();
        repeat (10000) begin
            @(negedge clk);
            g = grant;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (g[i] || !req[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    data_in[i*W +: W] = 8'($urandom);
                end
            end
            full = ($urandom_range(0, 3) == 0);
        end
        req  = '0;
        full = 1'b0;
        repeat (3) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_all_req();
        test_single();
        test_full_hold();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
